rwt_sample_pack: RTL and testbench



---
 rtl/rwt_sample_pack_if.sv | 33 +++
 rtl/rwt_sample_pack.sv | 100 ++++++++++
 tb/tb_rwt_sample_pack.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/rwt_sample_pack_if.sv
// rwt_sample_pack_if: the stream bus around the sample packer.
//   s_axi_*        : input sample stream, one beat = NCHAN channel samples,
//                    with a per-packet channel-enable mask (s_axi_enables)
//   m_axi_*        : packed output stream of full DWIDTH words
// Modports:
//   slave  - the packer (consumes s_axi_*, produces m_axi_*)
//   master - the surrounding logic / bench (produces s_axi_*, consumes m_axi_*)
interface rwt_sample_pack_if #(
    parameter int DWIDTH = 64,
    parameter int SWIDTH = 16
);
    localparam int NCHAN = DWIDTH / SWIDTH;

    logic [DWIDTH-1:0] s_axi_tdata;
    logic              s_axi_tvalid;
    logic              s_axi_tready;
    logic              s_axi_tlast;
    logic [NCHAN-1:0]  s_axi_enables;
    logic [DWIDTH-1:0] m_axi_tdata;
    logic              m_axi_tvalid;
    logic              m_axi_tready;
    logic              m_axi_tlast;

    modport slave (
        input  s_axi_tdata, s_axi_tvalid, s_axi_tlast, s_axi_enables, m_axi_tready,
        output s_axi_tready, m_axi_tdata, m_axi_tvalid, m_axi_tlast
    );

    modport master (
        output s_axi_tdata, s_axi_tvalid, s_axi_tlast, s_axi_enables, m_axi_tready,
        input  s_axi_tready, m_axi_tdata, m_axi_tvalid, m_axi_tlast
    );
endinterface

// File: rtl/rwt_sample_pack.sv
// rwt_sample_pack: drops disabled channels from each input beat and packs the
// enabled samples densely into full DWIDTH output words.
// Ports:
//   clk      - clock
//   aresetn  - asynchronous active-low reset
//   bus      - rwt_sample_pack_if.slave (s_axi_* input stream, m_axi_* output)
// The channel mask is captured on the first beat of each packet. A packet end
// flushes the remaining samples as a zero-padded last word.
module rwt_sample_pack #(
    parameter int DWIDTH = 64,
    parameter int SWIDTH = 16
) (
    input  logic                 clk,
    input  logic                 aresetn,
    rwt_sample_pack_if.slave     bus
);
    localparam int NCHAN = DWIDTH / SWIDTH;
    localparam int NSLOT = 2 * NCHAN;
    localparam int CW    = $clog2(NSLOT + 1);   // holds 0..2*NCHAN
    localparam int IW    = $clog2(NSLOT);       // slot index

    logic [NSLOT-1:0][SWIDTH-1:0] r_slots;
    logic [CW-1:0]                r_cnt;
    logic                         r_flush;
    logic                         r_first;
    logic [NCHAN-1:0]             r_en_q;
    logic                         r_live;       // low until the first clock after reset

    logic                         w_accept;
    logic                         w_pop;
    logic [NCHAN-1:0]             w_mask;
    logic [NSLOT-1:0][SWIDTH-1:0] w_slots_pop;
    logic [CW-1:0]                w_cnt_pop;
    logic [NSLOT-1:0][SWIDTH-1:0] w_slots_nxt;
    logic [CW-1:0]                w_idx;

    // All outputs come straight from registered state; m_axi_tready never
    // reaches s_axi_tready.
    assign bus.s_axi_tready = r_live && !r_flush && (r_cnt <= CW'(NCHAN));
    assign bus.m_axi_tvalid = (r_cnt >= CW'(NCHAN)) || (r_flush && r_cnt != '0);
    assign bus.m_axi_tlast  = r_flush && (r_cnt <= CW'(NCHAN)) && (r_cnt != '0);
    // Slots at or above cnt are always zero, so a partial word is already padded.
    assign bus.m_axi_tdata  = r_slots[NCHAN-1:0];

    assign w_accept = bus.s_axi_tvalid && bus.s_axi_tready;
    assign w_pop    = bus.m_axi_tvalid && bus.m_axi_tready;
    assign w_mask   = r_first ? bus.s_axi_enables : r_en_q;

    // Pop first, then append behind whatever is left.
    always_comb begin
        w_slots_pop = r_slots;
        w_cnt_pop   = r_cnt;
        if (w_pop) begin
            for (int i = 0; i < NCHAN; i++) begin
                w_slots_pop[i]         = r_slots[i+NCHAN];
                w_slots_pop[i+NCHAN]   = '0;
            end
            w_cnt_pop = (r_cnt >= CW'(NCHAN)) ? r_cnt - CW'(NCHAN) : '0;
        end
    end

    // Accept only happens with cnt <= NCHAN, so every write lands below NSLOT.
    always_comb begin
        w_slots_nxt = w_slots_pop;
        w_idx       = w_cnt_pop;
        if (w_accept) begin
            for (int c = 0; c < NCHAN; c++) begin
                if (w_mask[c]) begin
                    w_slots_nxt[w_idx[IW-1:0]] = bus.s_axi_tdata[c*SWIDTH +: SWIDTH];
                    w_idx = w_idx + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_slots <= '0;
            r_cnt   <= '0;
            r_flush <= 1'b0;
            r_first <= 1'b1;
            r_en_q  <= '0;
            r_live  <= 1'b0;
        end else begin
            r_live  <= 1'b1;
            r_slots <= w_slots_nxt;
            r_cnt   <= w_idx;
            if (w_accept) begin
                r_first <= bus.s_axi_tlast;
                if (r_first) r_en_q <= bus.s_axi_enables;
            end
            // An all-disabled packet leaves cnt=0 at flush: nothing to emit,
            // so flush retires on its own.
            if (w_accept && bus.s_axi_tlast)
                r_flush <= 1'b1;
            else if (r_flush && ((w_pop && bus.m_axi_tlast) || r_cnt == '0))
                r_flush <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rwt_sample_pack.sv
module tb_rwt_sample_pack;
    localparam int DWIDTH = 64;
    localparam int SWIDTH = 16;
    localparam int NCHAN  = DWIDTH / SWIDTH;

    typedef struct {
        logic [DWIDTH-1:0] d;
        logic              l;
    } exp_t;

    logic clk;
    logic aresetn;
    rwt_sample_pack_if #(.DWIDTH(DWIDTH), .SWIDTH(SWIDTH)) bus();

    rwt_sample_pack #(.DWIDTH(DWIDTH), .SWIDTH(SWIDTH)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .bus     (bus)
    );

    exp_t q[$];
    int   tests = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    logic throttle = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DWIDTH-1:0] w4(input logic [15:0] s3, input logic [15:0] s2,
                                             input logic [15:0] s1, input logic [15:0] s0);
        return {s3, s2, s1, s0};
    endfunction

    function automatic void expect_word(input logic [DWIDTH-1:0] d, input logic l);
        exp_t e;
        e.d = d;
        e.l = l;
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [DWIDTH-1:0] act, input logic [DWIDTH-1:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Beat b carries sample 0x{b}{c} on channel c. Starts and ends at posedge+1.
    task automatic send_beat(input int b, input logic [NCHAN-1:0] mask, input logic last);
        logic [DWIDTH-1:0] d;
        logic              acc;
        int                waits;
        for (int c = 0; c < NCHAN; c++) d[c*SWIDTH +: SWIDTH] = 16'((b << 8) | c);
        bus.s_axi_tdata   = d;
        bus.s_axi_enables = mask;
        bus.s_axi_tlast   = last;
        bus.s_axi_tvalid  = 1'b1;
        acc   = 1'b0;
        waits = 0;
        while (!acc) begin
            @(negedge clk);
            acc = bus.s_axi_tready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                stall_cnt++;
                if (waits > 100) begin
                    tests++;
                    errors++;
                    $display("FAIL accept_timeout: beat %0d not accepted, required accept within 100 cycles", b);
                    break;
                end
            end
        end
        bus.s_axi_tvalid = 1'b0;
        bus.s_axi_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d words outstanding, required 0", q.size());
        end
    endtask

    // Sink: always ready, or ready roughly one cycle in five when throttled.
    initial begin
        bus.m_axi_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.m_axi_tready = throttle ? ($urandom_range(0, 4) == 0) : 1'b1;
        end
    end

    // Monitor: sees the handshake that will complete on the next posedge.
    initial begin
        logic              prev_stall;
        logic [DWIDTH-1:0] prev_d;
        logic              prev_l;
        exp_t              e;
        prev_stall = 1'b0;
        prev_d     = '0;
        prev_l     = 1'b0;
        forever begin
            @(negedge clk);
            if (aresetn && bus.m_axi_tvalid) begin
                if (prev_stall) begin
                    check("stall_data", bus.m_axi_tdata, prev_d);
                    check("stall_last", DWIDTH'(bus.m_axi_tlast), DWIDTH'(prev_l));
                end
                if (bus.m_axi_tready) begin
                    prev_stall = 1'b0;
                    if (q.size() == 0) begin
                        tests++;
                        errors++;
                        $display("FAIL unexpected_word: got %h last=%0b, required no output",
                                 bus.m_axi_tdata, bus.m_axi_tlast);
                    end else begin
                        e = q.pop_front();
                        check("word_data", bus.m_axi_tdata, e.d);
                        check("word_last", DWIDTH'(bus.m_axi_tlast), DWIDTH'(e.l));
                    end
                end else begin
                    prev_stall = 1'b1;
                    prev_d     = bus.m_axi_tdata;
                    prev_l     = bus.m_axi_tlast;
                end
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        int s0;
        aresetn           = 1'b0;
        bus.s_axi_tdata   = '0;
        bus.s_axi_tvalid  = 1'b0;
        bus.s_axi_tlast   = 1'b0;
        bus.s_axi_enables = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", DWIDTH'(bus.m_axi_tvalid), '0);
        check("rst_tlast",  DWIDTH'(bus.m_axi_tlast), '0);
        check("rst_tdata",  bus.m_axi_tdata, '0);
        check("rst_tready", DWIDTH'(bus.s_axi_tready), '0);
        aresetn = 1'b1;
        #1;
        check("tready_before_clk", DWIDTH'(bus.s_axi_tready), '0);
        @(posedge clk);
        #1;
        check("tready_after_clk", DWIDTH'(bus.s_axi_tready), DWIDTH'(1));

        // Full mask: words pass verbatim at one beat per cycle.
        expect_word(w4(16'h0003, 16'h0002, 16'h0001, 16'h0000), 1'b0);
        expect_word(w4(16'h0103, 16'h0102, 16'h0101, 16'h0100), 1'b0);
        expect_word(w4(16'h0203, 16'h0202, 16'h0201, 16'h0200), 1'b1);
        s0 = stall_cnt;
        for (int b = 0; b < 3; b++) send_beat(b, 4'b1111, b == 2);
        check("full_mask_no_stall", DWIDTH'(stall_cnt - s0), '0);
        wait_drain();

        // Mask 0101: channels 0 and 2.
        expect_word(w4(16'h0102, 16'h0100, 16'h0002, 16'h0000), 1'b0);
        expect_word(w4(16'h0302, 16'h0300, 16'h0202, 16'h0200), 1'b1);
        for (int b = 0; b < 4; b++) send_beat(b, 4'b0101, b == 3);
        wait_drain();

        // Mask 0111: 9 samples spill across word boundaries.
        expect_word(w4(16'h0100, 16'h0002, 16'h0001, 16'h0000), 1'b0);
        expect_word(w4(16'h0201, 16'h0200, 16'h0102, 16'h0101), 1'b0);
        expect_word(w4(16'h0000, 16'h0000, 16'h0000, 16'h0202), 1'b1);
        for (int b = 0; b < 3; b++) send_beat(b, 4'b0111, b == 2);
        wait_drain();

        // Mid-packet mask change is ignored; next packet takes the new mask.
        expect_word(w4(16'h0300, 16'h0200, 16'h0100, 16'h0000), 1'b1);
        send_beat(0, 4'b0001, 1'b0);
        for (int b = 1; b < 4; b++) send_beat(b, 4'b1111, b == 3);
        expect_word(w4(16'h0403, 16'h0402, 16'h0401, 16'h0400), 1'b1);
        send_beat(4, 4'b1111, 1'b1);
        wait_drain();

        // All-disabled packet vanishes; the following packet is unaffected.
        expect_word(w4(16'h0000, 16'h0000, 16'h0000, 16'h0000), 1'b1);
        for (int b = 0; b < 5; b++) send_beat(b, 4'b0000, b == 4);
        send_beat(0, 4'b0001, 1'b1);
        wait_drain();

        // Throttled sink, mask 0011.
        throttle = 1'b1;
        expect_word(w4(16'h0101, 16'h0100, 16'h0001, 16'h0000), 1'b0);
        expect_word(w4(16'h0301, 16'h0300, 16'h0201, 16'h0200), 1'b0);
        expect_word(w4(16'h0501, 16'h0500, 16'h0401, 16'h0400), 1'b1);
        for (int b = 0; b < 6; b++) send_beat(b, 4'b0011, b == 5);
        wait_drain();
        throttle = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with two samples buffered; nothing stale may surface later.
        send_beat(7, 4'b0011, 1'b0);
        aresetn = 1'b0;
        #1;
        check("midrst_tvalid", DWIDTH'(bus.m_axi_tvalid), '0);
        check("midrst_tready", DWIDTH'(bus.s_axi_tready), '0);
        check("midrst_tdata",  bus.m_axi_tdata, '0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        expect_word(w4(16'h0000, 16'h0000, 16'h0801, 16'h0800), 1'b1);
        send_beat(8, 4'b0011, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
